// File: rtl/hist_bin_accumulator.sv
// Histogram read-modify-write front end: bins pixels, increments bin counts in an
// external single-clock dual-port RAM, and sweeps the RAM to zero after reset or on request.
module hist_bin_accumulator #(
    parameter int unsigned PIX_W  = 10,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 32
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              pix_valid,
    input  logic [PIX_W-1:0]  pix_data,
    output logic              pix_ready,
    input  logic              clear_req,
    output logic              clear_busy,
    output logic              clear_done,
    output logic              pipe_idle,
    output logic              sat_flag,
    output logic [ADDR_W-1:0] RdAddress,
    output logic              RdClockEn,
    input  logic [DATA_W-1:0] Q,
    output logic [ADDR_W-1:0] WrAddress,
    output logic [DATA_W-1:0] Data,
    output logic              WE,
    output logic              WrClockEn
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam logic [DATA_W-1:0] DATA_MAX  = '1;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e              state_q,      state_d;
    logic [ADDR_W-1:0]   clr_addr_q,   clr_addr_d;
    logic                pix_ready_q,  pix_ready_d;
    logic                clear_busy_q, clear_busy_d;
    logic                clear_done_q, clear_done_d;
    logic                pipe_idle_q,  pipe_idle_d;
    logic                sat_q,        sat_d;
    logic                en_q,         en_d;
    // S1: bin being read from the RAM
    logic                s1_v_q,       s1_v_d;
    logic [ADDR_W-1:0]   s1_bin_q,     s1_bin_d;
    // S2: read data returning, increment computed
    logic                s2_v_q,       s2_v_d;
    logic [ADDR_W-1:0]   s2_bin_q,     s2_bin_d;
    // S3: write port registers (shared with the clear sweep)
    logic                s3_v_q,       s3_v_d;
    logic                we_q,         we_d;
    logic [ADDR_W-1:0]   wr_addr_q,    wr_addr_d;
    logic [DATA_W-1:0]   wr_data_q,    wr_data_d;
    // Write committed on the previous edge; covers the read-old-data collision
    logic                wc_v_q,       wc_v_d;
    logic [ADDR_W-1:0]   wc_bin_q,     wc_bin_d;
    logic [DATA_W-1:0]   wc_data_q,    wc_data_d;

    logic                accept;
    logic [DATA_W-1:0]   base;
    logic                at_max;
    logic [DATA_W-1:0]   incr;

    // Next-state, pipeline advance, forwarding and registered-output computation
    always_comb begin
        state_d      = state_q;
        clr_addr_d   = clr_addr_q;
        clear_done_d = 1'b0;
        en_d         = 1'b1;

        accept   = pix_valid & pix_ready_q;
        s1_v_d   = accept;
        s1_bin_d = accept ? pix_data[PIX_W-1 -: ADDR_W] : s1_bin_q;
        s2_v_d   = s1_v_q;
        s2_bin_d = s1_bin_q;

        // Newest in-flight value of the bin wins over RAM data
        if (s3_v_q && (wr_addr_q == s2_bin_q)) begin
            base = wr_data_q;
        end else if (wc_v_q && (wc_bin_q == s2_bin_q)) begin
            base = wc_data_q;
        end else begin
            base = Q;
        end
        at_max = (base == DATA_MAX);
        incr   = at_max ? base : base + DATA_W'(1);

        s3_v_d    = s2_v_q;
        we_d      = s2_v_q;
        wr_addr_d = s2_bin_q;
        wr_data_d = incr;
        wc_v_d    = s3_v_q;
        wc_bin_d  = wr_addr_q;
        wc_data_d = wr_data_q;
        sat_d     = sat_q | (s2_v_q & at_max);

        case (state_q)
            CLEAR: begin
                we_d       = 1'b1;
                wr_addr_d  = clr_addr_q;
                wr_data_d  = '0;
                clr_addr_d = clr_addr_q + ADDR_W'(1);
                if (clr_addr_q == LAST_ADDR) begin
                    clear_done_d = 1'b1;
                    state_d      = ACCUM;
                end
            end
            ACCUM: begin
                if (clear_req) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pipe_idle_q) begin
                    state_d = CLEAR;
                end
            end
            default: begin
                state_d = CLEAR;
            end
        endcase

        if (state_d == CLEAR) begin
            sat_d = 1'b0;
        end

        clear_busy_d = (state_q == CLEAR);
        pix_ready_d  = (state_q == ACCUM) && (state_d == ACCUM);
        pipe_idle_d  = ~(s1_v_d | s2_v_d | s3_v_d);
    end

    // State and pipeline registers
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q      <= CLEAR;
            clr_addr_q   <= '0;
            pix_ready_q  <= 1'b0;
            clear_busy_q <= 1'b0;
            clear_done_q <= 1'b0;
            pipe_idle_q  <= 1'b0;
            sat_q        <= 1'b0;
            en_q         <= 1'b0;
            s1_v_q       <= 1'b0;
            s1_bin_q     <= '0;
            s2_v_q       <= 1'b0;
            s2_bin_q     <= '0;
            s3_v_q       <= 1'b0;
            we_q         <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            wc_v_q       <= 1'b0;
            wc_bin_q     <= '0;
            wc_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            clr_addr_q   <= clr_addr_d;
            pix_ready_q  <= pix_ready_d;
            clear_busy_q <= clear_busy_d;
            clear_done_q <= clear_done_d;
            pipe_idle_q  <= pipe_idle_d;
            sat_q        <= sat_d;
            en_q         <= en_d;
            s1_v_q       <= s1_v_d;
            s1_bin_q     <= s1_bin_d;
            s2_v_q       <= s2_v_d;
            s2_bin_q     <= s2_bin_d;
            s3_v_q       <= s3_v_d;
            we_q         <= we_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            wc_v_q       <= wc_v_d;
            wc_bin_q     <= wc_bin_d;
            wc_data_q    <= wc_data_d;
        end
    end

    assign pix_ready  = pix_ready_q;
    assign clear_busy = clear_busy_q;
    assign clear_done = clear_done_q;
    assign pipe_idle  = pipe_idle_q;
    assign sat_flag   = sat_q;
    assign RdAddress  = s1_bin_q;
    assign RdClockEn  = en_q;
    assign WrAddress  = wr_addr_q;
    assign Data       = wr_data_q;
    assign WE         = we_q;
    assign WrClockEn  = en_q;

endmodule

// File: tb/tb_hist_bin_accumulator.sv
// Bench for hist_bin_accumulator: behavioural dual-port RAM, reference histogram and write scoreboard.
`timescale 1ns/1ps
module tb_hist_bin_accumulator;

    localparam int PIX_W  = 10;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int NBINS  = 1024;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              pix_valid;
    logic [PIX_W-1:0]  pix_data;
    logic              pix_ready;
    logic              clear_req;
    logic              clear_busy;
    logic              clear_done;
    logic              pipe_idle;
    logic              sat_flag;
    logic [ADDR_W-1:0] RdAddress;
    logic              RdClockEn;
    logic [DATA_W-1:0] Q;
    logic [ADDR_W-1:0] WrAddress;
    logic [DATA_W-1:0] Data;
    logic              WE;
    logic              WrClockEn;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } exp_t;
    exp_t sb_q[$];
    exp_t mon_e;

    logic [DATA_W-1:0] ref_h [NBINS];
    logic [DATA_W-1:0] mem   [NBINS];

    // Backdoor controls applied inside the RAM process
    logic              bk_init = 1'b0;
    logic              bk_we   = 1'b0;
    logic [ADDR_W-1:0] bk_addr = '0;
    logic [DATA_W-1:0] bk_data = '0;

    always #5 clk = ~clk;

    hist_bin_accumulator #(.PIX_W(PIX_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .Clock(clk), .Reset(rst),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
        .clear_req(clear_req), .clear_busy(clear_busy), .clear_done(clear_done),
        .pipe_idle(pipe_idle), .sat_flag(sat_flag),
        .RdAddress(RdAddress), .RdClockEn(RdClockEn), .Q(Q),
        .WrAddress(WrAddress), .Data(Data), .WE(WE), .WrClockEn(WrClockEn)
    );

    // Dual-port RAM model: registered read, read-before-write on collision
    always @(posedge clk) begin
        if (bk_init) begin
            for (int i = 0; i < NBINS; i++) mem[i] <= 32'hDEAD_BEEF;
        end else if (bk_we) begin
            mem[bk_addr] <= bk_data;
        end
        if (WrClockEn && WE) mem[WrAddress] <= Data;
        if (RdClockEn) Q <= mem[RdAddress];
    end

    // Write monitor: clear sweep ordering and scoreboard of pixel writes
    int clr_idx = 0;
    always @(negedge clk) begin
        if (rst) begin
            clr_idx = 0;
        end else if (clear_busy) begin
            checks++;
            if (WE !== 1'b1 || Data !== '0 || WrAddress !== ADDR_W'(clr_idx) ||
                clear_done !== (clr_idx == NBINS - 1) || sb_q.size() != 0) begin
                errors++;
                $display("FAIL clear_write idx=%0d: WE=%b addr=%0d data=%h done=%b pending=%0d, required WE=1 addr=%0d data=0 done=%b pending=0",
                         clr_idx, WE, WrAddress, Data, clear_done, sb_q.size(), clr_idx, (clr_idx == NBINS - 1));
            end
            clr_idx = (clr_idx + 1) % NBINS;
        end else begin
            clr_idx = 0;
            checks++;
            if (clear_done !== 1'b0) begin
                errors++;
                $display("FAIL stray_clear_done: got %b, required 0", clear_done);
            end
            if (WE === 1'b1) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: addr=%0d data=%h, required no write", WrAddress, Data);
                end else begin
                    mon_e = sb_q.pop_front();
                    if (WrAddress !== mon_e.addr || Data !== mon_e.data) begin
                        errors++;
                        $display("FAIL pixel_write: got addr=%0d data=%h, required addr=%0d data=%h",
                                 WrAddress, Data, mon_e.addr, mon_e.data);
                    end
                end
            end
        end
    end

    // Reference increment for an accepted pixel and its expected RAM write
    task automatic push_exp(input logic [PIX_W-1:0] pix);
        logic [ADDR_W-1:0] bin;
        exp_t e;
        bin = pix[PIX_W-1 -: ADDR_W];
        if (ref_h[bin] != 32'hFFFF_FFFF) ref_h[bin] = ref_h[bin] + 32'd1;
        e.addr = bin;
        e.data = ref_h[bin];
        sb_q.push_back(e);
    endtask

    // One cycle of stimulus; called and returning at 1ns after a rising edge
    task automatic drive_pix(input logic v, input logic [PIX_W-1:0] d, input logic clr, output bit acc);
        pix_valid = v;
        pix_data  = d;
        clear_req = clr;
        @(negedge clk);
        acc = v && (pix_ready === 1'b1);
        if (acc) push_exp(d);
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
        clear_req = 1'b0;
    endtask

    task automatic check_mem(input string name);
        int bad = 0;
        int first = -1;
        for (int i = 0; i < NBINS; i++) begin
            if (mem[i] !== ref_h[i]) begin
                bad++;
                if (first < 0) first = i;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s: %0d bins differ, first bin %0d got %h, required %h",
                     name, bad, first, mem[first], ref_h[first]);
        end
    endtask

    task automatic wait_idle(input string name);
        bit ok = 0;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge clk);
            if (pipe_idle === 1'b1 && sb_q.size() == 0) ok = 1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_idle_timeout: pipe_idle=%b pending=%0d, required 1 and 0", name, pipe_idle, sb_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    // Waits for a whole sweep, then checks the handover back to accumulation
    task automatic wait_clear_done(input string name);
        int  busy = 0;
        bit  done = 0;
        for (int c = 0; c < 3000 && !done; c++) begin
            @(negedge clk);
            if (clear_busy === 1'b1) busy++;
            if (clear_done === 1'b1) done = 1;
        end
        checks++;
        if (!done || busy != NBINS) begin
            errors++;
            $display("FAIL %s_sweep: done=%b busy_cycles=%0d, required done=1 busy_cycles=%0d", name, done, busy, NBINS);
        end
        @(negedge clk);
        checks++;
        if (pix_ready !== 1'b1 || clear_busy !== 1'b0 || pipe_idle !== 1'b1) begin
            errors++;
            $display("FAIL %s_after_sweep: ready=%b busy=%b idle=%b, required 1 0 1", name, pix_ready, clear_busy, pipe_idle);
        end
        for (int i = 0; i < NBINS; i++) ref_h[i] = '0;
        check_mem({name, "_zeroed"});
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear(input string name);
        bit acc;
        drive_pix(1'b0, '0, 1'b1, acc);
        wait_clear_done(name);
    endtask

    task automatic test_reset();
        bk_init = 1'b1;
        @(posedge clk);
        #1;
        bk_init = 1'b0;
        @(negedge clk);
        checks++;
        if ({pix_ready, clear_busy, clear_done, pipe_idle, sat_flag, WE, RdClockEn, WrClockEn} !== 8'b0 ||
            RdAddress !== '0 || WrAddress !== '0 || Data !== '0) begin
            errors++;
            $display("FAIL reset_outputs: flags=%b rd=%0d wr=%0d data=%h, required all 0",
                     {pix_ready, clear_busy, clear_done, pipe_idle, sat_flag, WE, RdClockEn, WrClockEn},
                     RdAddress, WrAddress, Data);
        end
        // Interrupt a sweep part way; the next sweep must restart from address 0
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_clear_done("reset");
        checks++;
        if (RdClockEn !== 1'b1 || WrClockEn !== 1'b1 || sat_flag !== 1'b0) begin
            errors++;
            $display("FAIL clock_enables: rd_en=%b wr_en=%b sat=%b, required 1 1 0", RdClockEn, WrClockEn, sat_flag);
        end
    endtask

    task automatic test_back_to_back();
        bit acc;
        int nacc = 0;
        for (int i = 0; i < 1027; i++) begin
            drive_pix(1'b1, PIX_W'(i % NBINS), 1'b0, acc);
            if (acc) nacc++;
        end
        checks++;
        if (nacc != 1027) begin
            errors++;
            $display("FAIL b2b_accepts: got %0d, required 1027", nacc);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (pipe_idle !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle_early: got %b two cycles after last accept, required 0", pipe_idle);
        end
        @(negedge clk);
        checks++;
        if (pipe_idle !== 1'b1) begin
            errors++;
            $display("FAIL b2b_idle: got %b three cycles after last accept, required 1", pipe_idle);
        end
        @(posedge clk);
        #1;
        checks++;
        if (mem[0] !== 32'd2 || mem[2] !== 32'd2 || mem[3] !== 32'd1 || mem[1023] !== 32'd1) begin
            errors++;
            $display("FAIL b2b_bins: bins0/2/3/1023 got %0d %0d %0d %0d, required 2 2 1 1", mem[0], mem[2], mem[3], mem[1023]);
        end
        check_mem("b2b_all_bins");
    endtask

    task automatic test_same_bin();
        bit acc;
        do_clear("same_bin_clear");
        for (int i = 0; i < 100; i++) drive_pix(1'b1, PIX_W'(5), 1'b0, acc);
        wait_idle("same_bin");
        checks++;
        if (mem[5] !== 32'd100) begin
            errors++;
            $display("FAIL same_bin_count: got %0d, required 100", mem[5]);
        end
        check_mem("same_bin_all_bins");
    endtask

    task automatic test_gaps();
        bit acc;
        logic [PIX_W-1:0] vals [6];
        vals[0] = 10'd7; vals[1] = 10'd7; vals[2] = 10'd9;
        vals[3] = 10'd7; vals[4] = 10'd9; vals[5] = 10'd9;
        for (int gap = 0; gap < 3; gap++) begin
            do_clear("gap_clear");
            for (int k = 0; k < 6; k++) begin
                drive_pix(1'b1, vals[k], 1'b0, acc);
                for (int g = 0; g < gap; g++) drive_pix(1'b0, '0, 1'b0, acc);
            end
            wait_idle("gap");
            checks++;
            if (mem[7] !== 32'd3 || mem[9] !== 32'd3) begin
                errors++;
                $display("FAIL gap%0d_bins: bin7=%0d bin9=%0d, required 3 3", gap, mem[7], mem[9]);
            end
            check_mem("gap_all_bins");
        end
    endtask

    task automatic test_saturation();
        bit acc;
        do_clear("sat_clear");
        bk_we   = 1'b1;
        bk_addr = 10'd3;
        bk_data = 32'hFFFF_FFFE;
        @(posedge clk);
        #1;
        bk_we    = 1'b0;
        ref_h[3] = 32'hFFFF_FFFE;
        checks++;
        if (sat_flag !== 1'b0) begin
            errors++;
            $display("FAIL sat_pre: got %b, required 0", sat_flag);
        end
        for (int i = 0; i < 3; i++) drive_pix(1'b1, PIX_W'(3), 1'b0, acc);
        wait_idle("sat");
        checks++;
        if (mem[3] !== 32'hFFFF_FFFF || sat_flag !== 1'b1) begin
            errors++;
            $display("FAIL sat_bin: got bin3=%h sat=%b, required ffffffff 1", mem[3], sat_flag);
        end
        do_clear("sat_reclear");
        checks++;
        if (sat_flag !== 1'b0) begin
            errors++;
            $display("FAIL sat_cleared: got %b, required 0", sat_flag);
        end
    endtask

    task automatic test_clear_with_pixel();
        int  extra = 0;
        bit  done  = 0;
        pix_valid = 1'b1;
        pix_data  = 10'd4;
        clear_req = 1'b1;
        @(negedge clk);
        checks++;
        if (pix_ready !== 1'b1) begin
            errors++;
            $display("FAIL cwp_ready: got %b, required 1", pix_ready);
        end else begin
            push_exp(10'd4);
        end
        @(posedge clk);
        #1;
        clear_req = 1'b0;
        for (int c = 0; c < 3000 && !done; c++) begin
            @(negedge clk);
            if (pix_ready === 1'b1) extra++;
            if (clear_done === 1'b1) done = 1;
        end
        checks++;
        if (!done || extra != 0) begin
            errors++;
            $display("FAIL cwp_hold_off: done=%b extra_accepts=%0d, required 1 and 0", done, extra);
        end
        @(negedge clk);
        pix_valid = 1'b0;
        checks++;
        if (pix_ready !== 1'b1) begin
            errors++;
            $display("FAIL cwp_ready_after: got %b, required 1", pix_ready);
        end
        for (int i = 0; i < NBINS; i++) ref_h[i] = '0;
        check_mem("cwp_zeroed");
        @(posedge clk);
        #1;
    endtask

    initial begin
        pix_valid = 1'b0;
        pix_data  = '0;
        clear_req = 1'b0;
        for (int i = 0; i < NBINS; i++) ref_h[i] = '0;
        test_reset();
        test_back_to_back();
        test_same_bin();
        test_gaps();
        test_saturation();
        test_clear_with_pixel();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drained: %0d pending, required 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hist_bin_accumulator.md
Name: hist_bin_accumulator

Overview:
- Read-modify-write front end for the histogram pipeline.
- Takes a stream of pixel values, maps each to a bin and increments that bin's count in the downstream dual-port RAM (dpram, 1024 x 32).
- Owns both dpram ports on a single clock.
- Clears the whole histogram after reset and on request.

Parameters:
- PIX_W, 10, pixel value width; must be >= ADDR_W.
- ADDR_W, 10, bin address width (2^ADDR_W bins).
- DATA_W, 32, bin counter width.

Ports:
- Clock  in  1  single clock; drives dpram WrClock and RdClock externally.
- Reset  in  1  asynchronous, active-high.
- pix_valid  in  1  pixel present.
- pix_data  in  PIX_W  pixel value.
- pix_ready  out  1  pixel accepted when pix_valid & pix_ready at a rising edge.
- clear_req  in  1  single-cycle pulse; request histogram clear.
- clear_busy  out  1  clear sweep in progress.
- clear_done  out  1  one-cycle pulse on the last clear write.
- pipe_idle  out  1  no accepted pixel outstanding.
- sat_flag  out  1  sticky; some bin saturated since the last clear.
- RdAddress  out  ADDR_W  dpram read address.
- RdClockEn  out  1  dpram read clock enable.
- Q  in  DATA_W  dpram read data; valid one cycle after RdAddress is sampled.
- WrAddress  out  ADDR_W  dpram write address.
- Data  out  DATA_W  dpram write data.
- WE  out  1  dpram write enable.
- WrClockEn  out  1  dpram write clock enable.

Behaviour:
- Reset (async): all outputs 0, sat_flag 0, pipeline valids 0, FSM = CLEAR with clear address 0. RdClockEn and WrClockEn go 1 on the first edge after Reset deasserts and stay 1.
- Bin mapping: bin = pix_data[PIX_W-1 : PIX_W-ADDR_W], i.e. the top bits.
- FSM states: CLEAR, ACCUM, DRAIN.
- CLEAR:
  - pix_ready=0, clear_busy=1.
  - One write per cycle: WE=1, WrAddress=0..2^ADDR_W-1, Data=0.
  - clear_done pulses with the final write. sat_flag cleared on entry.
  - Next state ACCUM.
  - Reset during CLEAR restarts the sweep from address 0.
- ACCUM:
  - pix_ready=1.
  - On clear_req: pix_ready drops the next cycle and the FSM goes to DRAIN. A pixel accepted on the same edge as clear_req is still counted.
- DRAIN:
  - pix_ready=0.
  - Go to CLEAR when pipe_idle=1. clear_req in CLEAR/DRAIN is ignored.
- Pipeline, pixel accepted at edge t:
  - S1: bin registered at t; RdAddress=bin during cycle t..t+1; dpram samples at t+1.
  - S2: Q valid after t+1. Compute new = base+1, where base comes from the forwarding rules below. Registered at t+2 into the write stage.
  - S3: WE=1, WrAddress=bin, Data=new during cycle t+2..t+3; committed at edge t+3.
  - Full throughput: one pixel per cycle, no bubbles.
- Hazard forwarding:
  - Read and write at the same address on the same edge returns old data.
  - base = S3 write data if S3 valid and same bin (newest wins).
  - Else the previously committed write (registered one cycle) if valid and same bin.
  - Else Q.
  - Requirement: every accepted pixel increments its bin exactly once, for any sequence including identical consecutive bins.
- Saturation: if base = 2^DATA_W-1, new = base (no wrap) and sat_flag sets.
- pipe_idle=1 when S1, S2, S3 are all empty. Reset value 0; 1 in CLEAR.
- WE is never asserted in ACCUM except by S3. Clear writes and S3 writes never overlap because DRAIN waits for pipe_idle.

Test Plan:
- Reset release -> clear_busy=1 for 1024 cycles, WE=1 with WrAddress 0..1023 and Data=0, clear_done on address 1023; pix_ready=1 on the next cycle.
- 1027 pixels with pix_data = i mod 1024, back-to-back -> bins 0,1,2 = 2, all others = 1; pipe_idle=1 three cycles after the last accept.
- 100 consecutive pixels all value 5 -> bin 5 = 100, Data on consecutive writes = 1,2,...,100; no other bin written.
- Alternating values 7,7,9,7,9,9 with gaps of 0, 1 and 2 idle cycles -> bin 7 = 3, bin 9 = 3 for every gap pattern.
- Preload bin 3 = 0xFFFFFFFE, send three pixels of value 3 -> bin 3 = 0xFFFFFFFF, sat_flag=1; next clear_req -> sat_flag=0 and all bins 0.
- clear_req on the same edge as accepting a pixel of value 4, followed by pix_valid held high -> bin 4 written to 1 before the clear sweep starts, no further pixels accepted until clear_done+1, all bins 0 after the sweep.
